// File: rtl/mem_pkg.sv
// Shared types and default widths for the mem_if slave memory.
package mem_pkg;

  localparam int MEM_ADDR_W = 5;
  localparam int MEM_DATA_W = 8;

  typedef enum logic {INIT, RUN} mem_state_t;

  typedef logic [MEM_ADDR_W-1:0] addr_t;
  typedef logic [MEM_DATA_W-1:0] data_t;

endpackage

// File: rtl/mem_array.sv
// DEPTH x DATA_W register file: one synchronous write port, one registered read port.
module mem_array #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Storage is deliberately unreset; the owner overwrites it after reset.
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_slave.sv
// mem_if slave responder: post-reset clear sweep, then 1-cycle-latency reads and
// single-cycle writes, with a sticky conflict flag and saturating access counters.
module mem_slave
  import mem_pkg::*;
#(
  parameter int               ADDR_W   = MEM_ADDR_W,
  parameter int               DATA_W   = MEM_DATA_W,
  parameter int               CNT_W    = 16,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              ready,
  output logic              conflict,
  input  logic              clr_stat,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  wr_count,
  output mem_state_t        state_o
);

  // Handshake: read/write are one-cycle requests sampled at posedge and accepted
  // only while ready=1; there is no backpressure, requests seen in INIT are dropped.

  mem_state_t        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic              conflict_q, conflict_d;

  logic              run;
  logic              acc_wr, acc_rd, acc_both;
  logic              arr_we;
  logic [ADDR_W-1:0] arr_waddr;
  logic [DATA_W-1:0] arr_wdata;

  assign run      = (state_q == RUN);
  assign acc_wr   = run & write;
  assign acc_rd   = run & read & ~write;
  assign acc_both = run & read & write;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == INIT) begin
      ptr_d = ptr_q + 1'b1;
      if (ptr_q == {ADDR_W{1'b1}}) state_d = RUN;
    end
  end

  // The sweep owns the write port until RUN.
  assign arr_we    = run ? write   : 1'b1;
  assign arr_waddr = run ? addr    : ptr_q;
  assign arr_wdata = run ? data_in : INIT_VAL;

  always_comb begin
    rd_cnt_d   = rd_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    conflict_d = conflict_q;
    if (clr_stat) begin
      rd_cnt_d   = '0;
      wr_cnt_d   = '0;
      conflict_d = 1'b0;
    end else begin
      if (acc_rd && (rd_cnt_q != {CNT_W{1'b1}})) rd_cnt_d = rd_cnt_q + 1'b1;
      if (acc_wr && (wr_cnt_q != {CNT_W{1'b1}})) wr_cnt_d = wr_cnt_q + 1'b1;
      if (acc_both) conflict_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= INIT;
      ptr_q      <= '0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      conflict_q <= conflict_d;
    end
  end

  mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .we_i    (arr_we),
    .waddr_i (arr_waddr),
    .wdata_i (arr_wdata),
    .re_i    (acc_rd),
    .raddr_i (addr),
    .rdata_o (data_out)
  );

  assign ready    = run;
  assign conflict = conflict_q;
  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;
  assign state_o  = state_q;

endmodule
